// File: rtl/thermo_pkg.sv
// Shared constants, types and helpers for the thermometer display block.
package thermo_pkg;

    // Active-high segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_DASH  = 7'b1000000;

    // Display source selection; encoding 3 falls back to live
    localparam logic [1:0] MODE_LIVE = 2'd0;
    localparam logic [1:0] MODE_MIN  = 2'd1;
    localparam logic [1:0] MODE_MAX  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    // One BCD digit to its segment pattern; non-decimal codes show blank
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

    // Largest value displayable on n decimal digits (10^n - 1)
    function automatic logic [63:0] max_display(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble: one add-3/shift step per cycle, TEMP_W steps total.
// The first step is folded into the start cycle so the result is ready
// TEMP_W-1 cycles after start, with done pulsing alongside it.
module bin2bcd_seq
    import thermo_pkg::*;
#(
    parameter int unsigned TEMP_W     = 8,
    parameter int unsigned NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [TEMP_W-1:0]       bin_in,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd_out
);

    localparam int unsigned BCD_W = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W = $clog2(TEMP_W + 1);

    logic [TEMP_W-1:0] sr;
    logic [BCD_W-1:0]  bcd;
    logic [CNT_W-1:0]  cnt;

    // One double-dabble step: correct digits >= 5, then shift in the next bit
    function automatic logic [BCD_W-1:0] dd_step(input logic [BCD_W-1:0] b,
                                                 input logic bit_in);
        logic [BCD_W-1:0] a;
        a = b;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (a[4*i +: 4] >= 4'd5) begin
                a[4*i +: 4] = a[4*i +: 4] + 4'd3;
            end
        end
        return {a[BCD_W-2:0], bit_in};
    endfunction

    // Shift/add-3 sequencer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd  <= dd_step('0, bin_in[TEMP_W-1]);
                sr   <= bin_in << 1;
                cnt  <= CNT_W'(TEMP_W - 1);
                busy <= (TEMP_W > 1);
                done <= (TEMP_W == 1);
            end else if (busy) begin
                bcd <= dd_step(bcd, sr[TEMP_W-1]);
                sr  <= sr << 1;
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign bcd_out = bcd;

endmodule

// File: rtl/digital_thermometer_seq.sv
// Thermometer display: sample handshake, min/max tracking, hysteresis alarm,
// sequential BCD conversion and registered 7-segment outputs.
module digital_thermometer_seq
    import thermo_pkg::*;
#(
    parameter int unsigned TEMP_W     = 8,
    parameter int unsigned NUM_DIGITS = 3,
    parameter int unsigned BLANK_LZ   = 1,
    parameter int unsigned HYST       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [TEMP_W-1:0]       temperature,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [1:0]              mode,
    input  logic                    clear_minmax,
    input  logic [TEMP_W-1:0]       alarm_hi,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    busy,
    output logic                    done,
    output logic                    alarm
);

    localparam int unsigned BCD_W    = 4 * NUM_DIGITS;
    localparam int unsigned SEG_W    = 7 * NUM_DIGITS;
    localparam logic [63:0] MAX_DISP = max_display(NUM_DIGITS);

    state_t            state;
    logic [TEMP_W-1:0] min_reg;
    logic [TEMP_W-1:0] max_reg;
    logic              ovf_reg;

    logic              accept;
    logic              conv_start;
    logic              conv_busy;
    logic              conv_done;
    logic [BCD_W-1:0]  bcd;

    logic [TEMP_W-1:0] base_min;
    logic [TEMP_W-1:0] base_max;
    logic [TEMP_W-1:0] upd_min;
    logic [TEMP_W-1:0] upd_max;
    logic [TEMP_W-1:0] src_val;
    logic [TEMP_W-1:0] thr_lo;
    logic [SEG_W-1:0]  seg_next;

    assign sample_ready = ~busy;
    assign accept       = sample_valid & ~busy;
    assign conv_start   = accept & ~conv_busy;

    // Trackers after a same-cycle clear, then after folding in the new sample
    always_comb begin
        base_min = clear_minmax ? '1 : min_reg;
        base_max = clear_minmax ? '0 : max_reg;
        upd_min  = (temperature < base_min) ? temperature : base_min;
        upd_max  = (temperature > base_max) ? temperature : base_max;
        case (mode)
            MODE_MIN: src_val = upd_min;
            MODE_MAX: src_val = upd_max;
            default:  src_val = temperature;
        endcase
        thr_lo = (alarm_hi >= TEMP_W'(HYST)) ? (alarm_hi - TEMP_W'(HYST)) : '0;
    end

    bin2bcd_seq #(
        .TEMP_W     (TEMP_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst     (rst),
        .start   (conv_start),
        .bin_in  (src_val),
        .busy    (conv_busy),
        .done    (conv_done),
        .bcd_out (bcd)
    );

    // Digit patterns with overflow dashes and leading-zero blanking
    always_comb begin
        logic lead;
        seg_next = '0;
        lead     = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            if (ovf_reg) begin
                seg_next[7*i +: 7] = SEG_DASH;
            end else if ((BLANK_LZ != 0) && lead && (bcd[4*i +: 4] == 4'd0) && (i != 0)) begin
                seg_next[7*i +: 7] = SEG_BLANK;
            end else begin
                seg_next[7*i +: 7] = bcd_to_seg(bcd[4*i +: 4]);
                lead = 1'b0;
            end
        end
    end

    // Control FSM, trackers, alarm and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            alarm   <= 1'b0;
            seg_out <= '0;
            min_reg <= '1;
            max_reg <= '0;
            ovf_reg <= 1'b0;
        end else begin
            done <= 1'b0;
            if (clear_minmax && !accept) begin
                min_reg <= '1;
                max_reg <= '0;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        min_reg <= upd_min;
                        max_reg <= upd_max;
                        ovf_reg <= (64'(src_val) > MAX_DISP);
                        if (temperature >= alarm_hi) begin
                            alarm <= 1'b1;
                        end else if (temperature <= thr_lo) begin
                            alarm <= 1'b0;
                        end
                        busy  <= 1'b1;
                        state <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    seg_out <= seg_next;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digital_thermometer_seq.sv
// Scoreboard bench for digital_thermometer_seq (3-digit main DUT, 2-digit overflow DUT).
module tb_digital_thermometer_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  temperature;
    logic        sample_valid;
    logic        sample_ready;
    logic [1:0]  mode;
    logic        clear_minmax;
    logic [7:0]  alarm_hi;
    logic [20:0] seg_out;
    logic        busy;
    logic        done;
    logic        alarm;

    logic [7:0]  t2;
    logic        v2;
    logic        r2;
    logic [1:0]  mode2;
    logic        clr2;
    logic [7:0]  ahi2;
    logic [13:0] seg2;
    logic        busy2;
    logic        done2;
    logic        alarm2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [20:0] exp_q[$];
    logic [13:0] exp_q2[$];

    logic [7:0]  m_min;
    logic [7:0]  m_max;
    logic        m_alarm;

    always #5 clk = ~clk;

    digital_thermometer_seq #(.TEMP_W(8), .NUM_DIGITS(3), .BLANK_LZ(1), .HYST(2)) dut (
        .clk(clk), .rst(rst), .temperature(temperature), .sample_valid(sample_valid),
        .sample_ready(sample_ready), .mode(mode), .clear_minmax(clear_minmax),
        .alarm_hi(alarm_hi), .seg_out(seg_out), .busy(busy), .done(done), .alarm(alarm)
    );

    digital_thermometer_seq #(.TEMP_W(8), .NUM_DIGITS(2), .BLANK_LZ(1), .HYST(2)) dut2 (
        .clk(clk), .rst(rst), .temperature(t2), .sample_valid(v2),
        .sample_ready(r2), .mode(mode2), .clear_minmax(clr2),
        .alarm_hi(ahi2), .seg_out(seg2), .busy(busy2), .done(done2), .alarm(alarm2)
    );

    function automatic logic [6:0] digit_seg(input int d);
        case (d)
            0: return 7'b0111111;
            1: return 7'b0000110;
            2: return 7'b1011011;
            3: return 7'b1001111;
            4: return 7'b1100110;
            5: return 7'b1101101;
            6: return 7'b1111101;
            7: return 7'b0000111;
            8: return 7'b1111111;
            default: return 7'b1101111;
        endcase
    endfunction

    // Reference display pattern for value v on n digits
    function automatic logic [20:0] exp_seg(input int v, input int n);
        logic [20:0] r;
        int lim;
        int pw;
        int x;
        r = '0;
        lim = 1;
        for (int i = 0; i < n; i++) lim = lim * 10;
        if (v > lim - 1) begin
            for (int i = 0; i < n; i++) r[7*i +: 7] = 7'b1000000;
        end else begin
            x = v;
            pw = 1;
            for (int i = 0; i < n; i++) begin
                if (i == 0 || v >= pw) r[7*i +: 7] = digit_seg(x % 10);
                x = x / 10;
                pw = pw * 10;
            end
        end
        return r;
    endfunction

    // Drive one sample into the main DUT and push its expected display
    task automatic send(input logic [7:0] t, input logic [1:0] m, input logic clr);
        int k;
        logic [7:0] sel;
        logic [7:0] thr;
        k = 0;
        while (!sample_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (sample_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: sample_ready=%b required 1", sample_ready);
        end
        temperature  = t;
        mode         = m;
        clear_minmax = clr;
        sample_valid = 1'b1;
        if (clr) begin
            m_min = t;
            m_max = t;
        end else begin
            if (t < m_min) m_min = t;
            if (t > m_max) m_max = t;
        end
        sel = (m == 2'd1) ? m_min : (m == 2'd2) ? m_max : t;
        exp_q.push_back(exp_seg(int'(sel), 3));
        thr = (alarm_hi >= 8'd2) ? alarm_hi - 8'd2 : 8'd0;
        if (t >= alarm_hi) m_alarm = 1'b1;
        else if (t <= thr) m_alarm = 1'b0;
        @(negedge clk);
        sample_valid = 1'b0;
        clear_minmax = 1'b0;
        n_cmp++;
        if (alarm !== m_alarm) begin
            n_bad++;
            $display("FAIL alarm(t=%0d): alarm=%b required %b", t, alarm, m_alarm);
        end
        n_cmp++;
        if (busy !== 1'b1 || sample_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL busy_after_accept: busy=%b ready=%b required 1/0", busy, sample_ready);
        end
    endtask

    // Wait (bounded) for done, pop the expected display and compare
    task automatic collect(input string name, output int lat, output int bcnt);
        logic seen;
        logic [20:0] e;
        seen = 1'b0;
        lat  = 0;
        bcnt = 0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (done) seen = 1'b1;
            else if (busy) bcnt++;
        end
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 21'd0;
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL %s_timeout: done not seen in %0d cycles", name, lat);
        end else if (seg_out !== e) begin
            n_bad++;
            $display("FAIL %s_seg: seg_out=%b required %b", name, seg_out, e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (seg_out !== 21'd0 || busy !== 1'b0 || done !== 1'b0 || alarm !== 1'b0 || sample_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: seg=%b busy=%b done=%b alarm=%b ready=%b required 0/0/0/0/1",
                     seg_out, busy, done, alarm, sample_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_live();
        int lat;
        int bcnt;
        send(8'd25, 2'd0, 1'b0);
        collect("live25", lat, bcnt);
        n_cmp++;
        if (lat != 9) begin
            n_bad++;
            $display("FAIL live25_latency: %0d cycles required 9", lat);
        end
        n_cmp++;
        if (bcnt + 1 != 9) begin
            n_bad++;
            $display("FAIL live25_busy_len: busy %0d cycles required 9", bcnt + 1);
        end
        n_cmp++;
        if (seg_out !== {7'b0000000, 7'b1011011, 7'b1101101}) begin
            n_bad++;
            $display("FAIL live25_pattern: seg_out=%b required blank/2/5", seg_out);
        end
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || sample_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL live25_done_pulse: done=%b ready=%b required 0/1", done, sample_ready);
        end
    endtask

    task automatic test_full_and_mode3();
        int lat;
        int bcnt;
        send(8'd255, 2'd0, 1'b0);
        collect("full255", lat, bcnt);
        send(8'd123, 2'd3, 1'b0);
        collect("mode3_123", lat, bcnt);
    endtask

    task automatic test_minmax();
        int lat;
        int bcnt;
        send(8'd37, 2'd0, 1'b1);
        collect("mm37", lat, bcnt);
        send(8'd88, 2'd0, 1'b0);
        collect("mm88", lat, bcnt);
        send(8'd25, 2'd0, 1'b0);
        collect("mm25", lat, bcnt);
        send(8'd60, 2'd2, 1'b0);
        collect("max88", lat, bcnt);
        send(8'd60, 2'd1, 1'b0);
        collect("min25", lat, bcnt);
        send(8'd40, 2'd2, 1'b1);
        collect("clear40", lat, bcnt);
    endtask

    task automatic test_alarm();
        int lat;
        int bcnt;
        logic [7:0] samples[4];
        logic       req[4];
        samples = '{8'd70, 8'd75, 8'd74, 8'd73};
        req     = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send(samples[i], 2'd0, 1'b0);
            n_cmp++;
            if (alarm !== req[i]) begin
                n_bad++;
                $display("FAIL alarm_seq[%0d]: alarm=%b required %b", i, alarm, req[i]);
            end
            collect("alarm_disp", lat, bcnt);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        logic seen;
        logic ready_seen;
        logic [20:0] e;
        send(8'd48, 2'd0, 1'b0);
        temperature  = 8'd99;
        sample_valid = 1'b1;
        seen = 1'b0;
        ready_seen = 1'b0;
        k = 0;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            if (done) seen = 1'b1;
            else if (sample_ready) ready_seen = 1'b1;
        end
        sample_valid = 1'b0;
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 21'd0;
        n_cmp++;
        if (!seen || seg_out !== e) begin
            n_bad++;
            $display("FAIL drop_seg: seen=%b seg_out=%b required %b", seen, seg_out, e);
        end
        n_cmp++;
        if (ready_seen !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_ready: sample_ready rose during conversion, required 0");
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_no_restart: busy=%b required 0", busy);
        end
    endtask

    task automatic test_zero();
        int lat;
        int bcnt;
        send(8'd0, 2'd0, 1'b0);
        collect("zero", lat, bcnt);
        n_cmp++;
        if (seg_out !== {7'b0000000, 7'b0000000, 7'b0111111}) begin
            n_bad++;
            $display("FAIL zero_pattern: seg_out=%b required blank/blank/0", seg_out);
        end
    endtask

    task automatic test_reset_midconv();
        int lat;
        int bcnt;
        send(8'd77, 2'd0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (seg_out !== 21'd0 || busy !== 1'b0 || done !== 1'b0 || alarm !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset: seg=%b busy=%b done=%b alarm=%b required 0",
                     seg_out, busy, done, alarm);
        end
        exp_q.delete();
        m_min   = 8'hFF;
        m_max   = 8'h00;
        m_alarm = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(8'd64, 2'd2, 1'b0);
        collect("post_reset64", lat, bcnt);
        send(8'd9, 2'd1, 1'b0);
        collect("post_reset_min9", lat, bcnt);
    endtask

    task automatic test_overflow_2digit();
        int k;
        logic seen;
        logic [13:0] e;
        k = 0;
        while (!r2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        t2 = 8'd150;
        v2 = 1'b1;
        exp_q2.push_back(14'(exp_seg(150, 2)));
        @(negedge clk);
        v2 = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 30) begin
            @(negedge clk);
            k++;
            if (done2) seen = 1'b1;
        end
        e = (exp_q2.size() != 0) ? exp_q2.pop_front() : 14'd0;
        n_cmp++;
        if (!seen || seg2 !== e || e !== {7'b1000000, 7'b1000000}) begin
            n_bad++;
            $display("FAIL ovf2_seg: seen=%b seg_out=%b required %b", seen, seg2, e);
        end
    endtask

    initial begin
        rst          = 1'b1;
        temperature  = 8'd0;
        sample_valid = 1'b0;
        mode         = 2'd0;
        clear_minmax = 1'b0;
        alarm_hi     = 8'd75;
        t2           = 8'd0;
        v2           = 1'b0;
        mode2        = 2'd0;
        clr2         = 1'b0;
        ahi2         = 8'd200;
        m_min        = 8'hFF;
        m_max        = 8'h00;
        m_alarm      = 1'b0;

        test_reset();
        test_live();
        test_full_and_mode3();
        test_minmax();
        test_alarm();
        test_back_to_back();
        test_zero();
        test_reset_midconv();
        test_overflow_2digit();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
